// File: rtl/ps2_rx_frame.sv
// Host-side PS/2 device-to-host frame receiver: synchronises the raw lines, assembles
// start/8 data/odd parity/stop on ps2_clk falling edges, and emits one-cycle result pulses.
module ps2_rx_frame #(
   parameter int SYNC_STAGES   = 2,
   parameter int TIMEOUT_COUNT = 5000,
   parameter int TIMEOUT_WIDTH = 13,
   parameter logic [7:0] BAT_CODE = 8'hAA
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       inhibit,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_error,
   output logic       bat_detected,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   localparam logic [TIMEOUT_WIDTH-1:0] TIMER_MAX = TIMEOUT_WIDTH'(TIMEOUT_COUNT - 1);

   // Odd parity holds when the byte plus its parity bit carry an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] byte_in, input logic par_in);
      return ^{byte_in, par_in};
   endfunction

   logic [SYNC_STAGES-1:0]   clk_sync_r;
   logic [SYNC_STAGES-1:0]   data_sync_r;
   logic                     prev_clk_r;
   state_t                   state_r;
   logic [2:0]               bit_cnt_r;
   logic [7:0]               shift_r;
   logic                     parity_r;
   logic [TIMEOUT_WIDTH-1:0] timer_r;

   logic sync_clk_s;
   logic sync_data_s;
   logic fall_s;
   logic timeout_s;

   assign sync_clk_s  = clk_sync_r[SYNC_STAGES-1];
   assign sync_data_s = data_sync_r[SYNC_STAGES-1];
   assign fall_s      = prev_clk_r & ~sync_clk_s;
   assign timeout_s   = (timer_r == TIMER_MAX);

   // Input synchronisers and the previous-clock register used for falling-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_r  <= {SYNC_STAGES{1'b1}};
         data_sync_r <= {SYNC_STAGES{1'b1}};
         prev_clk_r  <= 1'b1;
      end else begin
         clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
         data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
         prev_clk_r  <= sync_clk_s;
      end
   end

   // Frame FSM; busy is updated on every transition so it tracks the state exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         bit_cnt_r    <= 3'd0;
         shift_r      <= 8'h00;
         parity_r     <= 1'b0;
         timer_r      <= '0;
         rx_data      <= 8'h00;
         rx_valid     <= 1'b0;
         rx_error     <= 1'b0;
         bat_detected <= 1'b0;
         busy         <= 1'b0;
      end else begin
         rx_valid     <= 1'b0;
         rx_error     <= 1'b0;
         bat_detected <= 1'b0;
         if (inhibit) begin
            state_r <= IDLE;
            timer_r <= '0;
            busy    <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  timer_r <= '0;
                  if (fall_s && !sync_data_s) begin
                     state_r   <= DATA;
                     bit_cnt_r <= 3'd0;
                     busy      <= 1'b1;
                  end else begin
                     busy <= 1'b0;
                  end
               end
               DATA: begin
                  if (fall_s) begin
                     shift_r[bit_cnt_r] <= sync_data_s;
                     bit_cnt_r          <= bit_cnt_r + 3'd1;
                     timer_r            <= '0;
                     if (bit_cnt_r == 3'd7) begin
                        state_r <= PARITY;
                     end else begin
                        state_r <= DATA;
                     end
                  end else if (timeout_s) begin
                     rx_error <= 1'b1;
                     state_r  <= IDLE;
                     timer_r  <= '0;
                     busy     <= 1'b0;
                  end else begin
                     timer_r <= timer_r + 1'b1;
                  end
               end
               PARITY: begin
                  if (fall_s) begin
                     parity_r <= sync_data_s;
                     timer_r  <= '0;
                     state_r  <= STOP;
                  end else if (timeout_s) begin
                     rx_error <= 1'b1;
                     state_r  <= IDLE;
                     timer_r  <= '0;
                     busy     <= 1'b0;
                  end else begin
                     timer_r <= timer_r + 1'b1;
                  end
               end
               STOP: begin
                  if (fall_s) begin
                     if (odd_parity_ok(shift_r, parity_r) && sync_data_s) begin
                        rx_data      <= shift_r;
                        rx_valid     <= 1'b1;
                        bat_detected <= (shift_r == BAT_CODE);
                     end else begin
                        rx_error <= 1'b1;
                     end
                     state_r <= IDLE;
                     timer_r <= '0;
                     busy    <= 1'b0;
                  end else if (timeout_s) begin
                     rx_error <= 1'b1;
                     state_r  <= IDLE;
                     timer_r  <= '0;
                     busy     <= 1'b0;
                  end else begin
                     timer_r <= timer_r + 1'b1;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  timer_r <= '0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
